// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed program image over a byte stream,
// assembles little-endian 32-bit words, writes them into instruction memory
// and keeps the core in reset until the image checksum has been verified.
//
// Frame: 0xA5, LEN_LO, LEN_HI, 4*N data bytes, CSUM (XOR of all data bytes).
//
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready.
// rx_ready is a pure function of the registered state and is low only in
// WRITE; rx_valid may stay high across that cycle and the byte is simply
// held off until the next cycle, so nothing is lost or duplicated.
module imem_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256,
    parameter int TIMEOUT   = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        dbg_state
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]     TMO_ONE   = TW'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WL_ONE    = (ADDR_W + 1)'(1);
    localparam logic [15:0]       MAX_LEN   = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [7:0]      len_lo;
    logic [15:0]     len;
    logic [7:0]      csum;
    logic [TW-1:0]   tmo_cnt;
    logic [1:0]      byte_idx;

    logic            accept;
    logic            is_sync;
    logic            counting;
    logic            tmo_fire;
    logic            last_word;
    logic [15:0]     len_n;
    logic [15:0]     wl_ext;

    assign rx_ready  = (state != WRITE);
    assign dbg_state = state;

    // Decode helpers: byte transfer, timeout expiry and end-of-image detection.
    always_comb begin
        accept    = rx_valid && rx_ready;
        is_sync   = (rx_data == SYNC_BYTE);
        counting  = (state == LEN_LO) || (state == LEN_HI) ||
                    (state == DATA)   || (state == CSUM);
        tmo_fire  = counting && !accept && (tmo_cnt == TMO_LAST);
        len_n     = {rx_data, len_lo};
        wl_ext    = 16'(words_loaded) + 16'd1;
        last_word = (wl_ext == len);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; an accepted byte always takes priority over the timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (accept && is_sync) next_state = LEN_LO;
            end
            LEN_LO: begin
                if (accept)        next_state = LEN_HI;
                else if (tmo_fire) next_state = ERROR;
            end
            LEN_HI: begin
                if (accept) begin
                    if (len_n == 16'd0 || len_n > MAX_LEN) next_state = ERROR;
                    else                                    next_state = DATA;
                end else if (tmo_fire) begin
                    next_state = ERROR;
                end
            end
            DATA: begin
                if (accept) begin
                    if (byte_idx == 2'd3) next_state = WRITE;
                end else if (tmo_fire) begin
                    next_state = ERROR;
                end
            end
            WRITE: begin
                next_state = last_word ? CSUM : DATA;
            end
            CSUM: begin
                if (accept)        next_state = (rx_data == csum) ? DONE : ERROR;
                else if (tmo_fire) next_state = ERROR;
            end
            ERROR: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, checksum, address/count and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_reset   <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
            words_loaded <= '0;
            csum         <= '0;
            len_lo       <= '0;
            len          <= '0;
            byte_idx     <= '0;
        end else begin
            // Write strobe is high exactly for the single WRITE cycle.
            im_we <= (next_state == WRITE);

            case (state)
                IDLE, DONE: begin
                    if (accept && is_sync) begin
                        core_reset   <= 1'b1;
                        load_done    <= 1'b0;
                        load_error   <= 1'b0;
                        im_addr      <= '0;
                        words_loaded <= '0;
                        csum         <= '0;
                        byte_idx     <= '0;
                    end
                end
                LEN_LO: begin
                    if (accept) len_lo <= rx_data;
                end
                LEN_HI: begin
                    if (accept) len <= len_n;
                end
                DATA: begin
                    if (accept) begin
                        im_wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    // The length check keeps N <= MAX_WORDS, so this wrap only
                    // matters after the final word of a full-size image.
                    im_addr      <= (im_addr == ADDR_LAST) ? '0 : im_addr + ADDR_ONE;
                    words_loaded <= words_loaded + WL_ONE;
                end
                CSUM: begin
                    if (accept && rx_data == csum) begin
                        load_done  <= 1'b1;
                        core_reset <= 1'b0;
                    end
                end
                default: ;
            endcase

            // Any failure path flags the error and keeps the core held.
            if (next_state == ERROR) begin
                load_error <= 1'b1;
                core_reset <= 1'b1;
                load_done  <= 1'b0;
            end
        end
    end

    // Inter-byte timeout: cleared by every accepted byte and outside a frame,
    // frozen while a word is being written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (counting) begin
            if (accept || tmo_fire) tmo_cnt <= '0;
            else                    tmo_cnt <= tmo_cnt + TMO_ONE;
        end else if (state != WRITE) begin
            tmo_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: framed loads, checksum and length
// failures, inter-byte timeout, handshake stalls, reload and async reset.
module tb_imem_boot_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;
    localparam int TIMEOUT   = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERROR = 3'd7;

    logic              clk;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              core_reset;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   words_loaded;
    logic [2:0]        dbg_state;

    int n_cmp;
    int n_err;
    int rdy_low;
    int rdy_low_we;

    // Expected and captured writes, each {addr, data}.
    logic [39:0] exp_q[$];
    logic [39:0] cap_q[$];

    imem_boot_loader #(
        .ADDR_W   (ADDR_W),
        .MAX_WORDS(MAX_WORDS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .im_we       (im_we),
        .im_addr     (im_addr),
        .im_wdata    (im_wdata),
        .core_reset  (core_reset),
        .load_done   (load_done),
        .load_error  (load_error),
        .words_loaded(words_loaded),
        .dbg_state   (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write capture and stall accounting, sampled mid-cycle.
    always @(negedge clk) begin
        if (im_we) cap_q.push_back({im_addr, im_wdata});
        if (!rx_ready) rdy_low++;
        if (!rx_ready && im_we) rdy_low_we++;
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until it transfers; starts and ends just after a negedge.
    task automatic send_byte(input logic [7:0] b);
        logic took;
        took     = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 8 && !took; i++) begin
            took = rx_ready;
            @(posedge clk);
            @(negedge clk);
        end
        if (!took) check("send_stall", 40'd0, 40'd1);
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_writes(input string tag);
        logic [39:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (cap_q.size() == 0) check({tag, "_missing"}, 40'd0, e);
            else                   check(tag, cap_q.pop_front(), e);
        end
        check({tag, "_extra"}, 40'(cap_q.size()), 40'd0);
        cap_q.delete();
    endtask

    initial begin
        logic [7:0] good_frame[$];
        logic [7:0] bad_frame[$];
        logic [7:0] one_frame[$];
        n_cmp = 0; n_err = 0; rdy_low = 0; rdy_low_we = 0;
        good_frame = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                       8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
        bad_frame  = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                       8'h13, 8'h01, 8'h10, 8'h00, 8'hC0};
        one_frame  = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};

        // Reset values.
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_state", 40'(dbg_state), 40'(S_IDLE));
        check("rst_core_reset", 40'(core_reset), 40'd1);
        check("rst_load_done", 40'(load_done), 40'd0);
        check("rst_load_error", 40'(load_error), 40'd0);
        check("rst_im_we", 40'(im_we), 40'd0);
        check("rst_im_addr", 40'(im_addr), 40'd0);
        check("rst_im_wdata", 40'(im_wdata), 40'd0);
        check("rst_words", 40'(words_loaded), 40'd0);
        check("rst_rx_ready", 40'(rx_ready), 40'd1);
        reset = 1'b1;
        idle(1);

        // Non-sync bytes in IDLE are dropped.
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
        idle(1);
        check("drop_state", 40'(dbg_state), 40'(S_IDLE));
        check("drop_core_reset", 40'(core_reset), 40'd1);
        check("drop_error", 40'(load_error), 40'd0);
        check("drop_no_write", 40'(cap_q.size()), 40'd0);

        // Good load with rx_valid held high throughout.
        rdy_low = 0; rdy_low_we = 0;
        send_frame(good_frame);
        check("good_state", 40'(dbg_state), 40'(S_DONE));
        check("good_load_done", 40'(load_done), 40'd1);
        check("good_core_reset", 40'(core_reset), 40'd0);
        check("good_words", 40'(words_loaded), 40'd2);
        check("good_error", 40'(load_error), 40'd0);
        check("hs_ready_low", 40'(rdy_low), 40'd2);
        check("hs_ready_low_we", 40'(rdy_low_we), 40'd2);
        exp_q.push_back({8'd0, 32'h00500093});
        exp_q.push_back({8'd1, 32'h00100113});
        check_writes("good_wr");

        // Reload: sync byte holds the core in reset from the next cycle.
        send_byte(8'hA5);
        rx_valid = 1'b0;
        check("reload_core_reset", 40'(core_reset), 40'd1);
        check("reload_load_done", 40'(load_done), 40'd0);
        one_frame.pop_front();
        send_frame(one_frame);
        check("reload_done", 40'(load_done), 40'd1);
        check("reload_words", 40'(words_loaded), 40'd1);
        exp_q.push_back({8'd0, 32'h12345678});
        check_writes("reload_wr");

        // Bad checksum: writes happen, then ERROR for one cycle, then IDLE.
        send_frame(bad_frame);
        check("badcs_state_err", 40'(dbg_state), 40'(S_ERROR));
        idle(1);
        check("badcs_state_idle", 40'(dbg_state), 40'(S_IDLE));
        check("badcs_error", 40'(load_error), 40'd1);
        check("badcs_core_reset", 40'(core_reset), 40'd1);
        check("badcs_load_done", 40'(load_done), 40'd0);
        exp_q.push_back({8'd0, 32'h00500093});
        exp_q.push_back({8'd1, 32'h00100113});
        check_writes("badcs_wr");

        // Zero length.
        send_frame('{8'hA5, 8'h00, 8'h00});
        check("len0_state", 40'(dbg_state), 40'(S_ERROR));
        idle(2);
        check("len0_error", 40'(load_error), 40'd1);
        check_writes("len0_wr");

        // Length 257 exceeds MAX_WORDS.
        send_frame('{8'hA5, 8'h01, 8'h01});
        check("len257_state", 40'(dbg_state), 40'(S_ERROR));
        idle(2);
        check("len257_error", 40'(load_error), 40'd1);
        check_writes("len257_wr");

        // Timeout: a byte arriving on the expiry cycle still wins.
        send_frame('{8'hA5, 8'h01, 8'h00, 8'h11});
        check("tmo_cleared_error", 40'(load_error), 40'd0);
        idle(TIMEOUT - 1);
        send_byte(8'h22);
        rx_valid = 1'b0;
        check("tmo_byte_wins", 40'(dbg_state), 40'(S_DATA));
        send_byte(8'h33);
        idle(TIMEOUT - 2);
        check("tmo_not_yet", 40'(load_error), 40'd0);
        idle(4);
        check("tmo_error", 40'(load_error), 40'd1);
        check("tmo_state", 40'(dbg_state), 40'(S_IDLE));
        check_writes("tmo_wr");
        send_frame(good_frame);
        check("after_tmo_done", 40'(load_done), 40'd1);
        check("after_tmo_error", 40'(load_error), 40'd0);
        exp_q.push_back({8'd0, 32'h00500093});
        exp_q.push_back({8'd1, 32'h00100113});
        check_writes("after_tmo_wr");

        // Asynchronous reset in the middle of DATA.
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
        check("mid_words", 40'(words_loaded), 40'd1);
        check("mid_state", 40'(dbg_state), 40'(S_DATA));
        #2 reset = 1'b0;
        #1;
        check("async_state", 40'(dbg_state), 40'(S_IDLE));
        check("async_im_addr", 40'(im_addr), 40'd0);
        check("async_words", 40'(words_loaded), 40'd0);
        check("async_wdata", 40'(im_wdata), 40'd0);
        check("async_core_reset", 40'(core_reset), 40'd1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back({8'd0, 32'h44332211});
        check_writes("mid_wr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Byte-stream program loader that sits directly upstream of the single-cycle core's instruction memory. It receives a framed program image over a valid/ready byte interface (fed by the UART receiver), assembles little-endian 32-bit instruction words and writes them into instruction memory. It holds the core in reset until a complete image with a correct checksum has been written.

Parameters:
ADDR_W, 8, instruction-memory word-index width.
MAX_WORDS, 256, largest accepted image in words; must be <= 2**ADDR_W.
TIMEOUT, 100000, maximum clk cycles allowed between accepted bytes inside a frame.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
rx_valid  input  1  byte available on rx_data.
rx_data  input  8  incoming byte.
rx_ready  output  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready.
im_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
im_addr  output  ADDR_W  word index being written.
im_wdata  output  32  instruction word being written.
core_reset  output  1  active-high reset to the core; 1 while loading or unloaded.
load_done  output  1  image loaded and verified.
load_error  output  1  last frame failed; sticky until the next sync byte.
words_loaded  output  ADDR_W+1  words written in the current or last frame.

Behaviour:
- Frame format: sync 0xA5, LEN_LO, LEN_HI (N = 16-bit word count, little-endian), 4N data bytes, CSUM. CSUM is the XOR of all 4N data bytes.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERROR.
- Reset (async assert, any state): state=IDLE, core_reset=1, load_done=0, load_error=0, im_we=0, im_addr=0, im_wdata=0, words_loaded=0, checksum and timeout counters 0. A reset in the middle of a load aborts it; words already written stay in memory.
- rx_ready = 1 in every state except WRITE, where it is 0. The combinational term is derived from the registered state.
- IDLE/DONE/ERROR handling:
  - IDLE and DONE: 0xA5 -> LEN_LO. On that transition core_reset=1, load_done=0, load_error=0, im_addr=0, words_loaded=0, checksum=0.
  - IDLE and DONE: any other byte is accepted and dropped.
  - ERROR: lasts one cycle, then IDLE. load_error=1 and core_reset=1 are held through IDLE until the next sync byte.
- LEN_LO -> LEN_HI on an accepted byte.
- LEN_HI: on an accepted byte, if N==0 or N>MAX_WORDS -> ERROR; else -> DATA.
- DATA:
  - Byte k (0..3) of a word lands in im_wdata[8k+7:8k]; each byte is XORed into the checksum.
  - On the 4th byte accepted at edge t: state WRITE during cycle t+1 with im_we=1 and im_addr/im_wdata valid.
  - At edge t+2: im_we=0, im_addr and words_loaded increment, state -> DATA, or -> CSUM if words_loaded reaches N.
- CSUM:
  - Accepted byte == checksum -> DONE. load_done=1 and core_reset=0 from the next cycle.
  - Mismatch -> ERROR.
- Timeout:
  - The counter clears on every accepted byte and on entry to LEN_LO.
  - It counts in LEN_LO, LEN_HI, DATA and CSUM; it is frozen in WRITE.
  - Reaching TIMEOUT-1 with no byte -> ERROR.
  - If a byte is accepted on the same cycle the timeout would fire, the byte wins.
- A sync byte inside a frame is ordinary data; no resynchronisation is performed.
- im_addr wraps only via the MAX_WORDS limit and never exceeds MAX_WORDS-1.

Test Plan:
- Good load: send A5 02 00 93 00 50 00 13 01 10 00 C1 -> im_we pulses at addr 0 data 0x00500093, then addr 1 data 0x00100113. After that, load_done=1, core_reset=0, words_loaded=2, load_error=0.
- Bad checksum: same frame with last byte C0 -> both writes still occur. Then load_error=1, core_reset=1, load_done=0, and the state returns to IDLE.
- Length limits: A5 00 00 -> ERROR right after LEN_HI, no im_we. A5 01 01 (N=257 > 256) -> ERROR, no im_we.
- Timeout: A5 01 00 followed by 3 data bytes, then idle TIMEOUT cycles -> load_error=1, no im_we. A following good frame loads successfully.
- Handshake: hold rx_valid=1 with a continuous stream -> rx_ready=0 exactly in the WRITE cycle after every 4th data byte, and no byte is lost or duplicated. Bytes 0x00 0xFF 0x13 in IDLE are dropped with no state change.
- Reload and reset: after a good load, send A5 -> core_reset=1 on the next cycle and a new image loads. Asserting reset low mid-DATA -> all outputs return to reset values immediately, without waiting for a clock edge.
